// File: rtl/dbus_responder_pkg.sv
// ---------------------------------------------------------------------------
// dbus_responder_pkg
//   Shared types for the data-bus responder slice:
//     - dbus_req_t / dbus_resp_t : the core's memory-stage request/response
//     - state_t                  : responder FSM states
//     - DEADCNT_W                : width of the latency down-counter
// ---------------------------------------------------------------------------
package dbus_responder_pkg;

  localparam int DEADCNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;

endpackage

// File: rtl/dbus_responder_if.sv
// ---------------------------------------------------------------------------
// dbus_responder_if
//   Bundles the request and response structs of one data-bus link.
//     dreq  : request from the initiator (core memory stage)
//     dresp : response from the responder
//   Handshake: a request is accepted in any cycle where dreq.valid and
//   dresp.addr_ok are both high; its completion is the single later cycle
//   with dresp.data_ok high, which also carries dresp.data. At most one
//   request is outstanding, and addr_ok is never high together with data_ok.
//   Modports: master = initiator side, slave = responder side.
// ---------------------------------------------------------------------------
interface dbus_responder_if;
  import dbus_responder_pkg::*;

  dbus_req_t  dreq;
  dbus_resp_t dresp;

  modport master (output dreq, input dresp);
  modport slave  (input dreq, output dresp);

endinterface

// File: rtl/dbus_responder_sram_be.sv
// ---------------------------------------------------------------------------
// dbus_responder_sram_be
//   MEM_WORDS x 32 word array, asynchronous read, synchronous write with
//   four byte-lane enables, gated by a global write enable.
//   Ports:
//     clk      : clock
//     we_i     : write enable for this cycle
//     be_i     : byte-lane enables, lane i = bits [8i+7:8i]
//     idx_i    : word index, shared by read and write
//     wdata_i  : write data
//     rdata_o  : current contents of word idx_i (pre-write value)
// ---------------------------------------------------------------------------
module dbus_responder_sram_be #(
  parameter int MEM_WORDS = 1024,
  parameter int IDX_W     = $clog2(MEM_WORDS)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [3:0]       be_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o
);

  // Contents start at zero and are never cleared by reset.
  logic [31:0] mem_q [MEM_WORDS] = '{default: 32'h0};

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int i = 0; i < 4; i++) begin
        if (be_i[i]) begin
          mem_q[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/dbus_responder.sv
// ---------------------------------------------------------------------------
// dbus_responder
//   Memory end of the core's data bus. Accepts one request at a time, waits
//   LATENCY cycles, then completes it with a one-cycle data_ok. Reads return
//   the addressed word; writes commit under the strobe mask at the clock edge
//   that ends the completion cycle.
//   Ports:
//     clk         : clock
//     resetn      : synchronous active-low reset
//     bus         : slave side of the request/response link (dreq in, dresp out)
//     busy        : high while a request is accepted but not completed
//     dbg_state_o : current FSM state, for observation only
// ---------------------------------------------------------------------------
module dbus_responder
  import dbus_responder_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 2,
  parameter int IDX_W     = $clog2(MEM_WORDS)
) (
  input  logic                   clk,
  input  logic                   resetn,
  dbus_responder_if.slave        bus,
  output logic                   busy,
  output state_t                 dbg_state_o
);

  state_t                 state_q, state_d;
  logic [DEADCNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [3:0]             strb_q, strb_d;
  logic [31:0]            data_q, data_d;

  logic                   mem_we;
  logic [31:0]            mem_rdata;
  dbus_resp_t             resp;

  // Byte offset, high address bits and size never influence indexing.
  logic unused_req;
  assign unused_req = ^{bus.dreq.addr[31:IDX_W+2], bus.dreq.addr[1:0], bus.dreq.size};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      strb_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      strb_q  <= strb_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    strb_d       = strb_q;
    data_d       = data_q;
    resp         = '0;
    mem_we       = 1'b0;

    case (state_q)
      IDLE: begin
        resp.addr_ok = bus.dreq.valid;
        if (bus.dreq.valid) begin
          idx_d   = bus.dreq.addr[IDX_W+1:2];
          strb_d  = bus.dreq.strobe;
          data_d  = bus.dreq.data;
          cnt_d   = DEADCNT_W'(LATENCY);
          state_d = (LATENCY == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == DEADCNT_W'(1)) begin
          state_d = RESP;
        end
      end
      RESP: begin
        resp.data_ok = 1'b1;
        resp.data    = mem_rdata;
        mem_we       = (strb_q != 4'b0000);
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are silent while reset is held; a write caught by reset on the
    // RESP edge is dropped rather than committed.
    if (!resetn) begin
      resp   = '0;
      mem_we = 1'b0;
    end
  end

  dbus_responder_sram_be #(
    .MEM_WORDS (MEM_WORDS),
    .IDX_W     (IDX_W)
  ) u_sram (
    .clk     (clk),
    .we_i    (mem_we),
    .be_i    (strb_q),
    .idx_i   (idx_q),
    .wdata_i (data_q),
    .rdata_o (mem_rdata)
  );

  assign bus.dresp   = resp;
  assign busy        = resetn && (state_q != IDLE);
  assign dbg_state_o = state_q;

endmodule
